// File: rtl/aes_pkg.sv
// Shared AES decryption types and constants: round counts, state width, controller FSM encoding.
package aes_pkg;

    localparam int NR_128   = 10;
    localparam int NR_192   = 12;
    localparam int NR_256   = 14;
    localparam int STATE_W  = 128;
    localparam int RK_IDX_W = 4;

    typedef logic [STATE_W-1:0]  blk_t;
    typedef logic [RK_IDX_W-1:0] rk_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/inv_cipher_ctrl_if.sv
// Block stream between the decryption front-end and the inverse cipher controller.
interface inv_cipher_ctrl_if;
    import aes_pkg::*;

    logic in_valid;
    logic in_ready;
    blk_t ct;
    logic out_valid;
    logic out_ready;
    blk_t pt;

    modport master (
        output in_valid, ct, out_ready,
        input  in_ready, out_valid, pt
    );

    modport slave (
        input  in_valid, ct, out_ready,
        output in_ready, out_valid, pt
    );

endinterface

// File: rtl/inv_cipher_ctrl.sv
// AES inverse cipher sequencer: initial AddRoundKey, then NR round-transform handshakes each followed by AddRoundKey.
// Result after NR*(L+1)+1 cycles; held in DONE until out_ready, no new block is accepted until then.
module inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic               clk,
    input  logic               rst_n,
    inv_cipher_ctrl_if.slave   dec_if,
    output logic               busy_o,
    output rk_idx_t            rk_idx_o,
    input  blk_t               rk_i,
    output logic               tf_start_o,
    output logic               tf_bypass_mc_o,
    output blk_t               tf_s_o,
    input  blk_t               tf_s_i,
    input  logic               tf_done_i
);

    localparam rk_idx_t NR_L = rk_idx_t'(NR);

    if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_nr_check
        $error("inv_cipher_ctrl: NR must be 10, 12 or 14");
    end

    ctrl_state_e state_q, state_d;
    blk_t        blk_q, blk_d;
    rk_idx_t     rnd_q, rnd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            rnd_q   <= rk_idx_t'(1);
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            rnd_q   <= rnd_d;
        end
    end

    // rnd never exceeds NR, so NR-rnd stays within 0..NR-1 without wrapping.
    always_comb begin
        state_d          = state_q;
        blk_d            = blk_q;
        rnd_d            = rnd_q;
        dec_if.in_ready  = 1'b0;
        dec_if.out_valid = 1'b0;
        tf_start_o       = 1'b0;
        tf_bypass_mc_o   = 1'b0;
        rk_idx_o         = NR_L;

        case (state_q)
            ST_IDLE: begin
                dec_if.in_ready = 1'b1;
                if (dec_if.in_valid) begin
                    blk_d   = dec_if.ct ^ rk_i;
                    rnd_d   = rk_idx_t'(1);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tf_start_o     = 1'b1;
                tf_bypass_mc_o = (rnd_q == rk_idx_t'(1));
                rk_idx_o       = NR_L - rnd_q;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                tf_bypass_mc_o = (rnd_q == rk_idx_t'(1));
                rk_idx_o       = NR_L - rnd_q;
                if (tf_done_i) begin
                    blk_d = tf_s_i ^ rk_i;
                    if (rnd_q == NR_L) begin
                        state_d = ST_DONE;
                    end else begin
                        rnd_d   = rnd_q + rk_idx_t'(1);
                        state_d = ST_START;
                    end
                end
            end
            ST_DONE: begin
                dec_if.out_valid = 1'b1;
                if (dec_if.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dec_if.pt = blk_q;
    assign tf_s_o    = blk_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Bench for inv_cipher_ctrl: behavioural inverse round transform and key store, FIPS-197 vectors for NR=10 and NR=14.
module tb_inv_cipher_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   lat;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]         in_valid, out_ready, spur_done;
    logic [1:0][127:0]  ct;
    logic [127:0]       spur_dat;
    logic [1:0]         in_ready, out_valid, busy, tf_start, tf_byp, tf_done;
    logic [1:0][127:0]  pt, tf_s_out, tf_s_in, rk;
    logic [1:0][3:0]    rk_idx;
    logic [1:0][15:0][127:0] rk_tbl;

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    logic [127:0] sb0 [$];
    logic [127:0] sb1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    inv_cipher_ctrl_if u_if10 ();
    inv_cipher_ctrl_if u_if14 ();

    assign u_if10.in_valid  = in_valid[0];
    assign u_if10.ct        = ct[0];
    assign u_if10.out_ready = out_ready[0];
    assign in_ready[0]      = u_if10.in_ready;
    assign out_valid[0]     = u_if10.out_valid;
    assign pt[0]            = u_if10.pt;

    assign u_if14.in_valid  = in_valid[1];
    assign u_if14.ct        = ct[1];
    assign u_if14.out_ready = out_ready[1];
    assign in_ready[1]      = u_if14.in_ready;
    assign out_valid[1]     = u_if14.out_valid;
    assign pt[1]            = u_if14.pt;

    inv_cipher_ctrl #(.NR(NR_128)) u_dut10 (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_if         (u_if10.slave),
        .busy_o         (busy[0]),
        .rk_idx_o       (rk_idx[0]),
        .rk_i           (rk[0]),
        .tf_start_o     (tf_start[0]),
        .tf_bypass_mc_o (tf_byp[0]),
        .tf_s_o         (tf_s_out[0]),
        .tf_s_i         (tf_s_in[0]),
        .tf_done_i      (tf_done[0])
    );

    inv_cipher_ctrl #(.NR(NR_256)) u_dut14 (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_if         (u_if14.slave),
        .busy_o         (busy[1]),
        .rk_idx_o       (rk_idx[1]),
        .rk_i           (rk[1]),
        .tf_start_o     (tf_start[1]),
        .tf_bypass_mc_o (tf_byp[1]),
        .tf_s_o         (tf_s_out[1]),
        .tf_s_i         (tf_s_in[1]),
        .tf_done_i      (tf_done[1])
    );

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, a, b;
        p = 8'h00; a = x; b = y;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Applies InvMixColumns first (unless bypassed), then InvShiftRows and InvSubBytes.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic byp);
        logic [7:0] b [16];
        logic [7:0] m [16];
        logic [7:0] r [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            if (byp) begin
                for (int j = 0; j < 4; j++) m[4*c+j] = b[4*c+j];
            end else begin
                m[4*c]   = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
                m[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
                m[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
                m[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
            end
        end
        for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
                r[4*c+row] = m[4*((c - row + 4) % 4) + row];
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[r[i]];
        return o;
    endfunction

    task automatic expand_key(input int k, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk = (k != 0) ? 8 : 4;
        nr = (k != 0) ? 14 : 10;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]});
                t[31:24] = t[31:24] ^ rcon;
                rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_tbl[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_tbl[k][r] = '0;
        end
    endtask

    // Round transform models: capture on the start edge, done pulse L cycles after start.
    int           cnt0, cnt1;
    logic [127:0] res0, res1;
    logic         mdone0, mdone1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= 0;
            res0 <= '0;
        end else if (tf_start[0]) begin
            cnt0 <= lat;
            res0 <= inv_round(tf_s_out[0], tf_byp[0]);
        end else if (cnt0 > 0) begin
            cnt0 <= cnt0 - 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= 0;
            res1 <= '0;
        end else if (tf_start[1]) begin
            cnt1 <= lat;
            res1 <= inv_round(tf_s_out[1], tf_byp[1]);
        end else if (cnt1 > 0) begin
            cnt1 <= cnt1 - 1;
        end
    end

    assign mdone0     = (cnt0 == 1);
    assign mdone1     = (cnt1 == 1);
    assign tf_done[0] = mdone0 | spur_done[0];
    assign tf_done[1] = mdone1 | spur_done[1];
    assign tf_s_in[0] = mdone0 ? res0 : spur_dat;
    assign tf_s_in[1] = mdone1 ? res1 : spur_dat;
    assign rk[0]      = rk_tbl[0][rk_idx[0]];
    assign rk[1]      = rk_tbl[1][rk_idx[1]];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input int k);
        chk("rst_in_ready",  128'(in_ready[k]),  128'd1);
        chk("rst_out_valid", 128'(out_valid[k]), 128'd0);
        chk("rst_busy",      128'(busy[k]),      128'd0);
        chk("rst_tf_start",  128'(tf_start[k]),  128'd0);
        chk("rst_bypass",    128'(tf_byp[k]),    128'd0);
        chk("rst_pt",        pt[k],              128'd0);
        chk("rst_tf_s",      tf_s_out[k],        128'd0);
        chk("rst_rk_idx",    128'(rk_idx[k]),    128'((k != 0) ? 14 : 10));
    endtask

    task automatic do_block(input int k, input logic [127:0] ctv, input logic [127:0] ptv,
                            input int hold, input bit spur, input bit rst_mid);
        int nr, a, nstart, nbyp;
        bit seen, aborted, mdone;
        logic [3:0]   rkseq [$];
        logic [127:0] ptq, exp;
        nr = (k != 0) ? 14 : 10;
        @(negedge clk);
        chk("idle_in_ready", 128'(in_ready[k]), 128'd1);
        chk("idle_rk_idx", 128'(rk_idx[k]), 128'(nr));
        in_valid[k] = 1'b1;
        ct[k] = ctv;
        a = cyc;
        if (k != 0) sb1.push_back(ptv); else sb0.push_back(ptv);
        rkseq.push_back(rk_idx[k]);
        @(negedge clk);
        in_valid[k] = 1'b0;
        nstart = 0; nbyp = 0; seen = 0; aborted = 0;
        for (int t = 0; t < 4000 && !seen && !aborted; t++) begin
            spur_done[k] = 1'b0;
            mdone = (k != 0) ? mdone1 : mdone0;
            if (out_valid[k]) begin
                seen = 1;
            end else begin
                if (tf_start[k]) begin
                    nstart++;
                    if (tf_byp[k]) nbyp++;
                    if (nstart == 1) chk("bypass_first", 128'(tf_byp[k]), 128'd1);
                    if (spur && nstart == 3) begin
                        spur_done[k] = 1'b1;
                        spur_dat = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
                if (mdone) rkseq.push_back(rk_idx[k]);
                if (spur && nstart == 4 && !tf_start[k]) begin
                    in_valid[k] = 1'b1;
                    ct[k] = ~ctv;
                    chk("wait_in_ready", 128'(in_ready[k]), 128'd0);
                end else begin
                    in_valid[k] = 1'b0;
                end
                if (rst_mid && nstart == 5 && !tf_start[k]) begin
                    #2 rst_n = 1'b0;
                    #1 chk_reset(k);
                    if (k != 0) exp = sb1.pop_back(); else exp = sb0.pop_back();
                    aborted = 1;
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        spur_done[k] = 1'b0;
        in_valid[k] = 1'b0;
        if (aborted) return;
        if (!seen) begin
            chk("out_valid_timeout", 128'd0, 128'd1);
            return;
        end
        chk("out_valid_cycle", 128'(cyc - a), 128'(nr * (lat + 1) + 1));
        chk("start_pulses", 128'(nstart), 128'(nr));
        chk("bypass_pulses", 128'(nbyp), 128'd1);
        chk("rk_seq_len", 128'(rkseq.size()), 128'(nr + 1));
        for (int i = 0; i < rkseq.size() && i <= nr; i++)
            chk("rk_seq", 128'(rkseq[i]), 128'(nr - i));
        ptq = pt[k];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_pt_stable", pt[k], ptq);
            chk("bp_in_ready", 128'(in_ready[k]), 128'd0);
            chk("bp_out_valid", 128'(out_valid[k]), 128'd1);
        end
        out_ready[k] = 1'b1;
        if (((k != 0) ? sb1.size() : sb0.size()) == 0) begin
            chk("scoreboard_empty", 128'd0, 128'd1);
        end else begin
            if (k != 0) exp = sb1.pop_front(); else exp = sb0.pop_front();
            chk("plaintext", pt[k], exp);
        end
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk("post_in_ready", 128'(in_ready[k]), 128'd1);
        chk("post_out_valid", 128'(out_valid[k]), 128'd0);
        if (spur) begin
            ptq = tf_s_out[k];
            spur_done[k] = 1'b1;
            spur_dat = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            spur_done[k] = 1'b0;
            chk("idle_spur_state", tf_s_out[k], ptq);
            chk("idle_spur_busy", 128'(busy[k]), 128'd0);
        end
    endtask

    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;

    initial begin
        rst_n = 1'b1;
        in_valid = '0;
        out_ready = '0;
        spur_done = '0;
        ct = '0;
        spur_dat = '0;
        lat = 1;
        for (int x = 0; x < 256; x++) sbox[x] = sbox_f(8'(x));
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        #2 rst_n = 1'b0;
        #1 chk_reset(0);
        chk_reset(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        lat = 1; do_block(0, CT_C1, PT_FIPS, 0, 1'b0, 1'b0);
        lat = 3; do_block(0, CT_C1, PT_FIPS, 5, 1'b1, 1'b0);
        lat = 2; do_block(0, CT_C1, PT_FIPS, 0, 1'b0, 1'b1);
        lat = 2; do_block(0, CT_C1, PT_FIPS, 1, 1'b0, 1'b0);
        lat = 1; do_block(1, CT_C3, PT_FIPS, 0, 1'b0, 1'b0);
        lat = 4; do_block(1, CT_C3, PT_FIPS, 2, 1'b1, 1'b0);

        chk("scoreboard_drained", 128'(sb0.size() + sb1.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
